int_ctrl: RTL and testbench



---
 rtl/int_ctrl.sv | 151 +++++++++++++++
 tb/tb_int_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// int_ctrl: four-line interrupt controller with input synchronisers, rising-edge
// pending latches, a per-line enable mask and fixed priority (line 0 highest).
// Only one interrupt is outstanding at a time: after a request is acknowledged,
// no new request is raised until the CPU signals return-from-interrupt.
module int_ctrl #(
    parameter logic [9:0] VEC0 = 10'b1111111011,
    parameter logic [9:0] VEC1 = 10'b1111111110,
    parameter logic [9:0] VEC2 = 10'b1111111101,
    parameter logic [9:0] VEC3 = 10'b1111111100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] irq_in,
    input  logic       mask_we,
    input  logic [3:0] mask_d,
    input  logic       int_ack,
    input  logic       reti,
    output logic       int_req,
    output logic [9:0] vector,
    output logic [3:0] pending,
    output logic       in_service
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] s3;
    logic [3:0] edge_det;
    logic [3:0] mask;
    logic [3:0] active;
    logic [3:0] ack_clr;
    logic [1:0] sel;
    logic [1:0] sel_lowest;
    logic [9:0] vec_lowest;

    // Three-stage shift per line: s1/s2 resolve metastability, s3 remembers the previous level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= irq_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // A line high at reset release still produces one event because s3 starts low
    assign edge_det = s2 & ~s3;

    // Enable mask; masked lines still latch pending but never raise a request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask <= '0;
        end else if (mask_we) begin
            mask <= mask_d;
        end
    end

    assign active = pending & mask;

    // Fixed-priority pick of the lowest enabled pending line and its vector
    always_comb begin
        sel_lowest = 2'd3;
        if (active[0]) begin
            sel_lowest = 2'd0;
        end else if (active[1]) begin
            sel_lowest = 2'd1;
        end else if (active[2]) begin
            sel_lowest = 2'd2;
        end
        case (sel_lowest)
            2'd0:    vec_lowest = VEC0;
            2'd1:    vec_lowest = VEC1;
            2'd2:    vec_lowest = VEC2;
            default: vec_lowest = VEC3;
        endcase
    end

    // Next-state logic; the ack also produces the clear mask for the serviced line
    always_comb begin
        state_next = state;
        ack_clr    = '0;
        unique case (state)
            IDLE: begin
                if (|active) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (int_ack) begin
                    state_next = SERVICE;
                    ack_clr    = 4'b0001 << sel;
                end
            end
            SERVICE: begin
                if (reti) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered outputs; sel and vector are frozen once a request has been raised
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_req    <= 1'b0;
            in_service <= 1'b0;
            sel        <= 2'd0;
            vector     <= '0;
        end else begin
            int_req    <= (state_next == REQ);
            in_service <= (state_next == SERVICE);
            if ((state == IDLE) && (state_next == REQ)) begin
                sel    <= sel_lowest;
                vector <= vec_lowest;
            end
        end
    end

    // Pending flags; a fresh edge on the acknowledged line wins over the ack clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~ack_clr) | edge_det;
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed stimulus for int_ctrl, checked every cycle against a
// behavioural model (input sample history, pending set, mask, request/service
// mode) plus hand-computed literal expectations at key points.
module tb_int_ctrl;

    localparam logic [9:0] VEC0 = 10'b1111111011;
    localparam logic [9:0] VEC1 = 10'b1111111110;
    localparam logic [9:0] VEC2 = 10'b1111111101;
    localparam logic [9:0] VEC3 = 10'b1111111100;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic [3:0] irq_in  = 4'b0000;
    logic       mask_we = 1'b0;
    logic [3:0] mask_d  = 4'b0000;
    logic       int_ack = 1'b0;
    logic       reti    = 1'b0;
    logic       int_req;
    logic [9:0] vector;
    logic [3:0] pending;
    logic       in_service;

    int checks_total  = 0;
    int checks_passed = 0;
    bit started       = 1'b0;

    // Model state: mode 0 = waiting, 1 = requesting, 2 = in service
    logic [3:0] m_pend = 4'b0000;
    logic [3:0] m_mask = 4'b0000;
    logic [3:0] m_hist [3];
    int         m_mode = 0;
    int         m_line = 0;

    int_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_d     (mask_d),
        .int_ack    (int_ack),
        .reti       (reti),
        .int_req    (int_req),
        .vector     (vector),
        .pending    (pending),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] vec_of(input int line);
        case (line)
            0:       return VEC0;
            1:       return VEC1;
            2:       return VEC2;
            default: return VEC3;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // One cycle: drive inputs after a falling edge, let one rising edge sample them
    task automatic applyStimulus(input logic [3:0] irq, input logic ack, input logic ret,
                                 input logic mwe, input logic [3:0] md);
        irq_in  = irq;
        int_ack = ack;
        reti    = ret;
        mask_we = mwe;
        mask_d  = md;
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    endtask

    // Behavioural model: an event is a sample high two edges ago that was low three edges ago
    initial begin
        logic [3:0] ev;
        logic [3:0] clr;
        logic [3:0] act;
        for (int i = 0; i < 3; i++) m_hist[i] = 4'b0000;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_pend = 4'b0000;
                m_mask = 4'b0000;
                m_mode = 0;
                m_line = 0;
                for (int i = 0; i < 3; i++) m_hist[i] = 4'b0000;
            end else begin
                ev  = m_hist[1] & ~m_hist[2];
                clr = 4'b0000;
                act = m_pend & m_mask;
                if (m_mode == 0) begin
                    if (act != 4'b0000) begin
                        for (int i = 3; i >= 0; i--) if (act[i]) m_line = i;
                        m_mode = 1;
                    end
                end else if (m_mode == 1) begin
                    if (int_ack) begin
                        clr[m_line] = 1'b1;
                        m_mode = 2;
                    end
                end else begin
                    if (reti) m_mode = 0;
                end
                m_pend = (m_pend & ~clr) | ev;
                if (mask_we) m_mask = mask_d;
                m_hist[2] = m_hist[1];
                m_hist[1] = m_hist[0];
                m_hist[0] = irq_in;
            end
        end
    end

    // Every falling edge out of reset, the DUT outputs must match the model
    initial begin
        forever begin
            @(negedge clk);
            if (started && !reset) begin
                checkOutput("model_int_req", {15'd0, int_req}, {15'd0, (m_mode == 1)});
                checkOutput("model_in_service", {15'd0, in_service}, {15'd0, (m_mode == 2)});
                checkOutput("model_pending", {12'd0, pending}, {12'd0, m_pend});
                if (m_mode == 1) checkOutput("model_vector", {6'd0, vector}, {6'd0, vec_of(m_line)});
            end
        end
    end

    initial begin
        int   rises;
        logic prev;

        repeat (2) @(negedge clk);
        checkOutput("reset_int_req", {15'd0, int_req}, 16'd0);
        checkOutput("reset_vector", {6'd0, vector}, 16'd0);
        checkOutput("reset_pending", {12'd0, pending}, 16'd0);
        checkOutput("reset_in_service", {15'd0, in_service}, 16'd0);
        reset   = 1'b0;
        started = 1'b1;

        $display("[TB] single event on line 2");
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1, 4'b1111);
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 4'b0000);
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 4'b0000);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
        checkOutput("t1_pending_edge3", {12'd0, pending}, 16'h0004);
        checkOutput("t1_no_req_edge3", {15'd0, int_req}, 16'd0);
        idleCycles(1);
        checkOutput("t1_req_edge4", {15'd0, int_req}, 16'd1);
        checkOutput("t1_vector", {6'd0, vector}, {6'd0, VEC2});
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);
        checkOutput("t1_ack_pending", {12'd0, pending}, 16'd0);
        checkOutput("t1_ack_in_service", {15'd0, in_service}, 16'd1);
        checkOutput("t1_ack_req_low", {15'd0, int_req}, 16'd0);
        idleCycles(2);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000);
        checkOutput("t1_reti_in_service", {15'd0, in_service}, 16'd0);
        idleCycles(2);
        checkOutput("t1_no_req_after_reti", {15'd0, int_req}, 16'd0);

        $display("[TB] simultaneous events on lines 3 and 1");
        applyStimulus(4'b1010, 1'b0, 1'b0, 1'b0, 4'b0000);
        applyStimulus(4'b1010, 1'b0, 1'b0, 1'b0, 4'b0000);
        idleCycles(2);
        checkOutput("t2_first_vector", {6'd0, vector}, {6'd0, VEC1});
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);
        checkOutput("t2_pending_after_ack", {12'd0, pending}, 16'h0008);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000);
        checkOutput("t2_req_low_at_reti", {15'd0, int_req}, 16'd0);
        idleCycles(1);
        checkOutput("t2_second_req", {15'd0, int_req}, 16'd1);
        checkOutput("t2_second_vector", {6'd0, vector}, {6'd0, VEC3});
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000);

        $display("[TB] masked line 0 then mask write");
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1, 4'b1110);
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000);
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
        checkOutput("t3_masked_pending", {12'd0, pending}, 16'h0001);
        idleCycles(10);
        checkOutput("t3_masked_no_req", {15'd0, int_req}, 16'd0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1, 4'b1111);
        checkOutput("t3_req_not_yet", {15'd0, int_req}, 16'd0);
        idleCycles(1);
        checkOutput("t3_req_after_unmask", {15'd0, int_req}, 16'd1);
        checkOutput("t3_vector", {6'd0, vector}, {6'd0, VEC0});
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000);

        $display("[TB] line 1 held high");
        rises = 0;
        prev  = int_req;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(4'b0010, (i == 4), (i == 6), 1'b0, 4'b0000);
            if (int_req && !prev) rises++;
            prev = int_req;
        end
        idleCycles(3);
        checkOutput("t4_one_request", rises[15:0], 16'd1);
        checkOutput("t4_pending_clear", {12'd0, pending}, 16'd0);

        $display("[TB] line 0 arrives while line 3 requested");
        applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0, 4'b0000);
        applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0, 4'b0000);
        idleCycles(2);
        checkOutput("t5_vector_line3", {6'd0, vector}, {6'd0, VEC3});
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000);
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000);
        idleCycles(2);
        checkOutput("t5_vector_frozen", {6'd0, vector}, {6'd0, VEC3});
        checkOutput("t5_pending_both", {12'd0, pending}, 16'h0009);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000);
        idleCycles(1);
        checkOutput("t5_line0_served", {6'd0, vector}, {6'd0, VEC0});
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000);

        $display("[TB] new edge coincides with ack");
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 4'b0000);
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 4'b0000);
        idleCycles(2);
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 4'b0000);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);
        checkOutput("t7_set_wins", {12'd0, pending}, 16'h0004);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000);
        idleCycles(1);
        checkOutput("t7_rerequest_vector", {6'd0, vector}, {6'd0, VEC2});
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000);

        $display("[TB] stray ack and reti in idle");
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000);
        checkOutput("t8_idle_in_service", {15'd0, in_service}, 16'd0);
        checkOutput("t8_idle_req", {15'd0, int_req}, 16'd0);

        $display("[TB] reset during service");
        applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0, 4'b0000);
        applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0, 4'b0000);
        idleCycles(2);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);
        applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000);
        applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
        checkOutput("t6_pending_before", {12'd0, pending}, 16'h0002);
        checkOutput("t6_service_before", {15'd0, in_service}, 16'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("t6_async_pending", {12'd0, pending}, 16'd0);
        checkOutput("t6_async_in_service", {15'd0, in_service}, 16'd0);
        checkOutput("t6_async_int_req", {15'd0, int_req}, 16'd0);
        checkOutput("t6_async_vector", {6'd0, vector}, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        idleCycles(6);
        checkOutput("t6_no_req_after_release", {15'd0, int_req}, 16'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
